// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the phase-lock supervisory controller.
// Holds the state encodings, fault codes, the default legal DDS
// increment window and the tracking loop's initial increment.
package phase_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_RETRY   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_RETRIES = 2'd2;
    localparam logic [1:0] FC_WINDOW  = 2'd3;

    localparam logic [14:0] F_MIN_DEFAULT  = 15'd26000;
    localparam logic [14:0] F_MAX_DEFAULT  = 15'd30000;
    localparam logic [14:0] INIT_INCREMENT = 15'b110111000000000;

    localparam int unsigned TIMEOUT_W = 12;
    localparam int unsigned HOLD_W    = 8;
    localparam int unsigned RUN_W     = 5;

endpackage

// File: rtl/tick_run_counter.sv
// Saturating up-counter advanced by a tick-qualified enable.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear, wins over inc
//   inc         - advance by one this cycle (already tick-qualified)
//   term_hit    - count is at TERM, or reaches TERM on this cycle's inc
module tick_run_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TERM  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term_hit
);

    localparam logic [WIDTH-1:0] TERM_V    = WIDTH'(TERM);
    localparam logic [WIDTH-1:0] TERM_M1_V = WIDTH'(TERM - 1);

    logic [WIDTH-1:0] cnt;
    logic             at_term;

    assign at_term = (cnt == TERM_V);
    // Looking one increment ahead lets the FSM act on the same edge the
    // count lands on the terminal value.
    assign term_hit = at_term || (inc && (cnt == TERM_M1_V));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_lock_sequencer.sv
// Supervisory sequencer for the ultrasonic drive phase-tracking loop.
// Decides standby/run of the tracking loop, gates amplifier drive,
// qualifies lock, retries after lock loss and latches faults.
// Ports:
//   clk, rst_n   - 50 MHz clock, asynchronous active-low reset
//   tick         - 5 kHz single-cycle control strobe
//   enable       - operator cut request (level)
//   locked       - lock indication from the tracking loop
//   increment    - current DDS increment from the tracking loop
//   standby      - hold tracking loop at its initial increment
//   drive_en     - power-amplifier enable
//   tracking     - high only in TRACK
//   fault        - latched fault
//   fault_code   - 0 none, 1 acquire timeout, 2 retries, 3 window
//   state        - current state encoding
//   retry_cnt    - lock-loss retries used in this run
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | drive off, loop in standby, waiting for enable
// ACQUIRE  | drive on, waiting for CONFIRM_TICKS consecutive locks
// TRACK    | locked and running, watching for lock loss
// RETRY    | drive off for HOLD_TICKS before re-acquiring
// FAULT    | latched fault, cleared only by dropping enable
module phase_lock_sequencer
    import phase_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 2500,
    parameter int unsigned CONFIRM_TICKS = 8,
    parameter int unsigned UNLOCK_TICKS  = 16,
    parameter int unsigned HOLD_TICKS    = 250,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [14:0] F_MIN         = F_MIN_DEFAULT,
    parameter logic [14:0] F_MAX         = F_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        enable,
    input  logic        locked,
    input  logic [14:0] increment,
    output logic        standby,
    output logic        drive_en,
    output logic        tracking,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state,
    output logic [1:0]  retry_cnt
);

    if (TIMEOUT_TICKS == 0 || TIMEOUT_TICKS >= (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("TIMEOUT_TICKS does not fit the timeout counter");
    end
    if (HOLD_TICKS == 0 || HOLD_TICKS >= (1 << HOLD_W)) begin : g_bad_hold
        $error("HOLD_TICKS does not fit the hold counter");
    end
    if (CONFIRM_TICKS == 0 || CONFIRM_TICKS >= (1 << RUN_W)) begin : g_bad_confirm
        $error("CONFIRM_TICKS does not fit the confirm counter");
    end
    if (UNLOCK_TICKS == 0 || UNLOCK_TICKS >= (1 << RUN_W)) begin : g_bad_unlock
        $error("UNLOCK_TICKS does not fit the unlock counter");
    end
    if (MAX_RETRY > 3) begin : g_bad_retry
        $error("MAX_RETRY does not fit retry_cnt");
    end
    if (F_MIN > F_MAX) begin : g_bad_window
        $error("F_MIN must not exceed F_MAX");
    end

    localparam logic [1:0] MAX_RETRY_V = MAX_RETRY[1:0];

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [1:0] retry_q, retry_d;
    logic       standby_q, drive_en_q, tracking_q, fault_q;

    logic in_acquire, in_track, in_retry;
    logic confirm_hit, unlock_hit, timeout_hit, hold_hit;
    logic out_of_window;

    assign in_acquire    = (state_q == ST_ACQUIRE);
    assign in_track      = (state_q == ST_TRACK);
    assign in_retry      = (state_q == ST_RETRY);
    assign out_of_window = (increment < F_MIN) || (increment > F_MAX);

    // Each counter is held clear whenever its owning state is not active,
    // so entering a state always starts its count from zero.
    tick_run_counter #(.WIDTH(RUN_W), .TERM(CONFIRM_TICKS)) u_confirm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_acquire || (tick && !locked)),
        .inc      (tick && locked),
        .term_hit (confirm_hit)
    );

    tick_run_counter #(.WIDTH(RUN_W), .TERM(UNLOCK_TICKS)) u_unlock (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_track || (tick && locked)),
        .inc      (tick && !locked),
        .term_hit (unlock_hit)
    );

    tick_run_counter #(.WIDTH(TIMEOUT_W), .TERM(TIMEOUT_TICKS)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_acquire),
        .inc      (tick),
        .term_hit (timeout_hit)
    );

    tick_run_counter #(.WIDTH(HOLD_W), .TERM(HOLD_TICKS)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!in_retry),
        .inc      (tick),
        .term_hit (hold_hit)
    );

    // Priority: fault entry, then enable drop, then tick-driven moves.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACQUIRE;
                    retry_d = 2'd0;
                end
            end
            ST_ACQUIRE: begin
                if (out_of_window) begin
                    state_d = ST_FAULT;
                    code_d  = FC_WINDOW;
                end else if (confirm_hit) begin
                    // Qualified lock outranks a coincident timeout.
                    state_d = enable ? ST_TRACK : ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                    code_d  = FC_TIMEOUT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (out_of_window) begin
                    state_d = ST_FAULT;
                    code_d  = FC_WINDOW;
                end else if (unlock_hit && (retry_q >= MAX_RETRY_V)) begin
                    state_d = ST_FAULT;
                    code_d  = FC_RETRIES;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (unlock_hit) begin
                    state_d = ST_RETRY;
                    retry_d = retry_q + 2'd1;
                end
            end
            ST_RETRY: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (hold_hit) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_FAULT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = ST_FAULT;
                code_d  = FC_RETRIES;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so drive_en
    // has no combinational path from locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= FC_NONE;
            retry_q    <= 2'd0;
            standby_q  <= 1'b1;
            drive_en_q <= 1'b0;
            tracking_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            retry_q    <= retry_d;
            standby_q  <= !((state_d == ST_ACQUIRE) || (state_d == ST_TRACK));
            drive_en_q <= (state_d == ST_ACQUIRE) || (state_d == ST_TRACK);
            tracking_q <= (state_d == ST_TRACK);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign state      = state_q;
    assign fault_code = code_q;
    assign retry_cnt  = retry_q;
    assign standby    = standby_q;
    assign drive_en   = drive_en_q;
    assign tracking   = tracking_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_phase_lock_sequencer.sv
// Scoreboard bench for phase_lock_sequencer: the stimulus thread pushes
// hand-computed expected output snapshots, a monitor pops and compares
// them on the falling clock edge.
module tb_phase_lock_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACQ  = 3'd1;
    localparam logic [2:0] S_TRK  = 3'd2;
    localparam logic [2:0] S_RTY  = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n, tick, enable, locked;
    logic [14:0] increment;
    logic        standby, drive_en, tracking, fault;
    logic [1:0]  fault_code, retry_cnt;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       sb;
        logic       de;
        logic       tr;
        logic       fl;
        logic [1:0] fc;
        logic [1:0] rc;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    obs_t mon_got;
    int   checks   = 0;
    int   failures = 0;

    phase_lock_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .enable     (enable),
        .locked     (locked),
        .increment  (increment),
        .standby    (standby),
        .drive_en   (drive_en),
        .tracking   (tracking),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {state, standby, drive_en, tracking, fault, fault_code, retry_cnt};
            checks++;
            if (mon_got !== mon_e.exp) begin
                failures++;
                $display("FAIL %s: got st=%0d sb=%b de=%b tr=%b fl=%b fc=%0d rc=%0d, exp st=%0d sb=%b de=%b tr=%b fl=%b fc=%0d rc=%0d",
                         mon_e.name, mon_got.st, mon_got.sb, mon_got.de, mon_got.tr, mon_got.fl,
                         mon_got.fc, mon_got.rc, mon_e.exp.st, mon_e.exp.sb, mon_e.exp.de,
                         mon_e.exp.tr, mon_e.exp.fl, mon_e.exp.fc, mon_e.exp.rc);
            end
        end
    end

    task automatic expect_st(input string nm, input logic [2:0] st,
                             input logic [1:0] fc, input logic [1:0] rc);
        exp_t e;
        logic run;
        run      = (st == S_ACQ) || (st == S_TRK);
        e.name   = nm;
        e.exp    = {st, !run, run, (st == S_TRK), (st == S_FLT), fc, rc};
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; consumes exactly one edge.
    task automatic cycle(input logic tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // n ticks separated by idle cycles; expectation after every tick.
    task automatic tick_n(input string nm, input int n,
                          input logic [2:0] st_mid, input logic [1:0] fc_mid, input logic [1:0] rc_mid,
                          input logic [2:0] st_end, input logic [1:0] fc_end, input logic [1:0] rc_end);
        for (int k = 1; k <= n; k++) begin
            cycle(1'b1);
            if (k == n) expect_st(nm, st_end, fc_end, rc_end);
            else        expect_st(nm, st_mid, fc_mid, rc_mid);
            cycle(1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        enable    = 1'b0;
        locked    = 1'b0;
        increment = 15'd28160;
        repeat (2) @(posedge clk);
        #1;
        expect_st("reset", S_IDLE, 2'd0, 2'd0);
        cycle(1'b0);
        rst_n = 1'b1;
        cycle(1'b0);
        expect_st("idle_wait", S_IDLE, 2'd0, 2'd0);

        // Lock from tick 3 onward: TRACK on tick 10.
        enable = 1'b1;
        cycle(1'b0);
        expect_st("acq_entry", S_ACQ, 2'd0, 2'd0);
        tick_n("acq_unlocked", 2, S_ACQ, 2'd0, 2'd0, S_ACQ, 2'd0, 2'd0);
        locked = 1'b1;
        tick_n("acq_confirm", 8, S_ACQ, 2'd0, 2'd0, S_TRK, 2'd0, 2'd0);

        // Window edges are legal.
        increment = 15'd26000;
        cycle(1'b0);
        expect_st("win_fmin", S_TRK, 2'd0, 2'd0);
        increment = 15'd30000;
        cycle(1'b0);
        expect_st("win_fmax", S_TRK, 2'd0, 2'd0);
        increment = 15'd28160;

        // Three recoverable lock losses, fourth is fatal.
        for (int r = 0; r < 4; r++) begin
            locked = 1'b0;
            if (r < 3) begin
                tick_n("unlock", 16, S_TRK, 2'd0, 2'(r), S_RTY, 2'd0, 2'(r + 1));
                tick_n("hold", 250, S_RTY, 2'd0, 2'(r + 1), S_ACQ, 2'd0, 2'(r + 1));
                locked = 1'b1;
                tick_n("relock", 8, S_ACQ, 2'd0, 2'(r + 1), S_TRK, 2'd0, 2'(r + 1));
            end else begin
                tick_n("retries_out", 16, S_TRK, 2'd0, 2'd3, S_FLT, 2'd2, 2'd3);
            end
        end
        cycle(1'b0);
        expect_st("fault2_held", S_FLT, 2'd2, 2'd3);
        enable = 1'b0;
        cycle(1'b0);
        expect_st("fault2_clear", S_IDLE, 2'd0, 2'd3);
        enable = 1'b1;
        cycle(1'b0);
        expect_st("retry_reset", S_ACQ, 2'd0, 2'd0);

        // Seven locked ticks then loss: confirm restarts, timeout on tick 2500.
        locked = 1'b1;
        tick_n("near_confirm", 7, S_ACQ, 2'd0, 2'd0, S_ACQ, 2'd0, 2'd0);
        locked = 1'b0;
        tick_n("timeout", 2493, S_ACQ, 2'd0, 2'd0, S_FLT, 2'd1, 2'd0);
        cycle(1'b0);
        expect_st("fault1_held", S_FLT, 2'd1, 2'd0);
        enable = 1'b0;
        cycle(1'b0);
        expect_st("fault1_clear", S_IDLE, 2'd0, 2'd0);

        // Below-window increment in TRACK.
        enable = 1'b1;
        cycle(1'b0);
        expect_st("acq_entry2", S_ACQ, 2'd0, 2'd0);
        locked = 1'b1;
        tick_n("confirm2", 8, S_ACQ, 2'd0, 2'd0, S_TRK, 2'd0, 2'd0);
        increment = 15'd25999;
        cycle(1'b0);
        expect_st("win_low", S_FLT, 2'd3, 2'd0);
        increment = 15'd28160;
        cycle(1'b1);
        expect_st("fault3_held", S_FLT, 2'd3, 2'd0);
        enable = 1'b0;
        cycle(1'b0);
        expect_st("fault3_clear", S_IDLE, 2'd0, 2'd0);

        // Above-window increment in ACQUIRE.
        enable = 1'b1;
        cycle(1'b0);
        expect_st("acq_entry3", S_ACQ, 2'd0, 2'd0);
        increment = 15'd30001;
        cycle(1'b0);
        expect_st("win_high", S_FLT, 2'd3, 2'd0);
        increment = 15'd28160;
        enable = 1'b0;
        cycle(1'b0);
        expect_st("fault3b_clear", S_IDLE, 2'd0, 2'd0);

        // Enable drop in TRACK.
        enable = 1'b1;
        cycle(1'b0);
        tick_n("confirm3", 8, S_ACQ, 2'd0, 2'd0, S_TRK, 2'd0, 2'd0);
        enable = 1'b0;
        cycle(1'b0);
        expect_st("enable_drop", S_IDLE, 2'd0, 2'd0);

        // Asynchronous reset while in RETRY.
        enable = 1'b1;
        cycle(1'b0);
        tick_n("confirm4", 8, S_ACQ, 2'd0, 2'd0, S_TRK, 2'd0, 2'd0);
        locked = 1'b0;
        tick_n("unlock4", 16, S_TRK, 2'd0, 2'd0, S_RTY, 2'd0, 2'd1);
        tick_n("hold4", 5, S_RTY, 2'd0, 2'd1, S_RTY, 2'd0, 2'd1);
        enable = 1'b0;
        rst_n  = 1'b0;
        expect_st("rst_async", S_IDLE, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1);
        expect_st("post_rst_idle", S_IDLE, 2'd0, 2'd0);
        cycle(1'b0);
        expect_st("post_rst_idle2", S_IDLE, 2'd0, 2'd0);
        enable = 1'b1;
        cycle(1'b0);
        expect_st("post_rst_acq", S_ACQ, 2'd0, 2'd0);

        cycle(1'b0);
        cycle(1'b0);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phase_lock_sequencer.md
Name: phase_lock_sequencer

Overview:
Supervisory controller for the anti-resonant phase-tracking loop of the ultrasonic cutting drive. It decides when the tracking loop is held in standby and when it runs, and it gates the power-amplifier drive. It qualifies lock, retries after lock loss, and latches a fault on timeout, excess retries or frequency-window violation. It sits between the operator enable and the phase_control loop / DDS increment path, clocked by the 50 MHz system clock and paced by the 5 kHz control tick.

Parameters:
TIMEOUT_TICKS, 2500, ticks allowed in ACQUIRE before lock is qualified (0.5 s at 5 kHz)
CONFIRM_TICKS, 8, consecutive locked ticks required to enter TRACK
UNLOCK_TICKS, 16, consecutive unlocked ticks in TRACK that declare lock loss
HOLD_TICKS, 250, standby hold time in RETRY before re-acquire
MAX_RETRY, 3, lock-loss retries allowed before FAULT
F_MIN, 15'd26000, lowest legal DDS increment
F_MAX, 15'd30000, highest legal DDS increment

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle 5 kHz control strobe (same as loop update rate)
enable  in  1  operator cut request, level
locked  in  1  lock indication from tracking loop
increment  in  15  current DDS increment from tracking loop
standby  out  1  holds tracking loop at its initial increment when 1
drive_en  out  1  power-amplifier enable
tracking  out  1  high only in TRACK
fault  out  1  latched fault
fault_code  out  2  0 none, 1 acquire timeout, 2 retries exhausted, 3 frequency out of window
state  out  3  current state encoding
retry_cnt  out  2  retries used in the current run

Behaviour:
- Reset is asynchronous and active-low (rst_n). It forces state=IDLE, standby=1, drive_en=0, tracking=0, fault=0, fault_code=0, retry_cnt=0, and all counters 0. Reset mid-operation aborts immediately; the same rules apply.
- All registers update on posedge clk. Counters advance only in cycles where tick=1; state transitions driven by enable or by the window check may occur on any cycle.
- States: IDLE=0, ACQUIRE=1, TRACK=2, RETRY=3, FAULT=4.
- IDLE: standby=1, drive_en=0. If enable=1 → ACQUIRE; clear timeout_cnt, confirm_cnt and retry_cnt.
- ACQUIRE: standby=0, drive_en=1.
  - Each tick: timeout_cnt+1.
  - Each tick: confirm_cnt+1 if locked=1, else confirm_cnt=0.
  - confirm_cnt reaching CONFIRM_TICKS → TRACK. This takes priority over timeout on the same tick.
  - Otherwise, timeout_cnt reaching TIMEOUT_TICKS → FAULT with code 1.
- TRACK: standby=0, drive_en=1, tracking=1.
  - Each tick: unlock_cnt+1 if locked=0, else unlock_cnt=0.
  - unlock_cnt reaching UNLOCK_TICKS:
    - if retry_cnt<MAX_RETRY → RETRY, retry_cnt+1;
    - else → FAULT with code 2.
- RETRY: standby=1, drive_en=0. After HOLD_TICKS ticks → ACQUIRE; clear timeout_cnt and confirm_cnt. retry_cnt is preserved.
- Frequency window: in ACQUIRE or TRACK, if increment<F_MIN or increment>F_MAX (unsigned compare) on any cycle → FAULT with code 3.
  - The window check takes priority over the tick-driven transitions in the same cycle.
  - Equality with F_MIN or F_MAX is legal.
- FAULT: standby=1, drive_en=0, fault=1. fault_code is held and cannot be overwritten.
  - Exit only when enable=0 → IDLE, which clears fault and fault_code.
  - retry_cnt holds its value until the next IDLE→ACQUIRE.
- enable=0 in ACQUIRE, TRACK or RETRY → IDLE on the next clk edge. This takes priority over every other transition except entry to FAULT.
- Outputs are registered and valid one clk after the transition decision. The combinational path from locked to drive_en is forbidden.
- Counters saturate at their terminal value. timeout_cnt is 12 bits, hold_cnt is 8 bits, confirm_cnt and unlock_cnt are 5 bits. Parameter values must fit these widths; this is checked by an elaboration-time assertion.
- Illegal state encodings (5–7) → FAULT with code 2.

Decomposition:
- Shared package phase_ctrl_pkg holds:
  - state encodings, fault codes;
  - the default F_MIN/F_MAX;
  - the initial increment 15'b110111000000000.
- One natural sub-module, tick_run_counter: a saturating counter with a tick enable, a synchronous clear, and a terminal flag. Instantiate it for each of confirm, unlock, timeout and hold.

Test Plan:
- Reset, then enable=1, with locked=1 from tick 3 onward and increment=28160 → TRACK after tick 10; tracking=1, standby=0, drive_en=1, retry_cnt=0.
- enable=1 with locked never asserted → FAULT on tick 2500; fault_code=1, drive_en=0, standby=1. Then enable=0 → IDLE with fault=0.
- In TRACK, drop locked for 16 ticks → RETRY, standby=1 for 250 ticks, then ACQUIRE. Repeat 4 times → 4th loss gives FAULT with code 2 and retry_cnt=3.
- In TRACK, set increment=25999 → FAULT with code 3 on the next clk. increment=26000 or 30000 → stays in TRACK.
- In TRACK, deassert enable → IDLE next clk: standby=1, drive_en=0, no fault.
- Pulse rst_n low for 1 cycle while in RETRY → all outputs at reset values immediately, asynchronously; stays in IDLE until enable=1.
